// File: rtl/booth_multiplier_seq.sv
// Sequential radix-4 Booth multiplier, two multiplier bits retired per clock.
// Operands are extended by two bits so unsigned mode reuses the signed datapath.
module booth_multiplier_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q;
    logic [AW-1:0]      acc_q;
    logic [AW-1:0]      m_q;
    logic [EW:0]        b_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] result_q;

    logic [EW-1:0]      a_ext_d;
    logic [EW-1:0]      b_ext_d;
    logic [AW-1:0]      pp_d;
    logic [AW-1:0]      acc_d;
    logic               last_d;

    always_comb begin
        a_ext_d = {{2{signed_mode & A[WIDTH-1]}}, A};
        b_ext_d = {{2{signed_mode & B[WIDTH-1]}}, B};
    end

    // m_q is pre-shifted by 4^i, so the triplet in b_q[2:0] selects the digit
    always_comb begin
        pp_d = '0;
        unique case (b_q[2:0])
            3'b001, 3'b010: pp_d = m_q;
            3'b011:         pp_d = m_q << 1;
            3'b100:         pp_d = -(m_q << 1);
            3'b101, 3'b110: pp_d = -m_q;
            default:        pp_d = '0;
        endcase
        acc_d  = acc_q + pp_d;
        last_d = (cnt_q == CW'(ITER - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            m_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= {{(AW-EW){a_ext_d[EW-1]}}, a_ext_d};
                        b_q     <= {b_ext_d, 1'b0};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    m_q   <= m_q << 2;
                    b_q   <= {b_q[EW], b_q[EW], b_q[EW:2]};
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) begin
                        result_q <= acc_d[2*WIDTH-1:0];
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Scoreboard bench for booth_multiplier_seq with WIDTH=8 and WIDTH=16 instances.
// Directed operands with hand-computed products and completion cycles.
module tb_booth_multiplier_seq;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic        sm8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] result8;
    logic        start16 = 1'b0;
    logic        sm16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16;
    logic        done16;
    logic [31:0] result16;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q16[$];

    booth_multiplier_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .result(result8)
    );

    booth_multiplier_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .A(a16), .B(b16), .busy(busy16), .done(done16), .result(result16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL done8_unexpected: result=%h cyc=%0d", result8, cyc);
            end else begin
                e = q8.pop_front();
                if (result8 !== e.res[15:0] || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result8: got %h at cyc %0d, want %h at cyc %0d",
                             result8, cyc, e.res[15:0], e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done16) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL done16_unexpected: result=%h cyc=%0d", result16, cyc);
            end else begin
                e = q16.pop_front();
                if (result16 !== e.res || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL result16: got %h at cyc %0d, want %h at cyc %0d",
                             result16, cyc, e.res, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Called at posedge+#1; the start is sampled at the next edge.
    task automatic issue8(input bit sm, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] res, input bit push);
        exp_t e;
        sm8 = sm;
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        if (push) begin
            e.res = {16'h0, res};
            e.cyc = cyc + 1 + 5;
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = $urandom;
        b8 = $urandom;
        sm8 = $urandom;
    endtask

    task automatic issue16(input bit sm, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] res);
        exp_t e;
        sm16 = sm;
        a16 = a;
        b16 = b;
        start16 = 1'b1;
        e.res = res;
        e.cyc = cyc + 1 + 9;
        q16.push_back(e);
        @(posedge clk);
        #1;
        start16 = 1'b0;
        a16 = $urandom;
        b16 = $urandom;
        sm16 = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q8.size() != 0 || q16.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (q8.size() != 0 || q16.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending8=%0d pending16=%0d",
                     q8.size(), q16.size());
            q8.delete();
            q16.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy8", {31'h0, busy8}, 32'h0);
        check("reset_done8", {31'h0, done8}, 32'h0);
        check("reset_result8", {16'h0, result8}, 32'h0);
        check("reset_result16", result16, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("busy8_run", {31'h0, busy8}, 32'h1);
            @(posedge clk);
            #1;
        end
        check("busy8_end", {31'h0, busy8}, 32'h0);
        check("done8_end", {31'h0, done8}, 32'h1);
        @(posedge clk);
        #1;
        check("done8_pulse", {31'h0, done8}, 32'h0);
        drain();

        issue8(1'b1, 8'd127, 8'h80, 16'hC080, 1'b1);
        drain();
        issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
        drain();
        issue8(1'b0, 8'h80, 8'h02, 16'h0100, 1'b1);
        drain();
        issue8(1'b1, 8'hAA, 8'd85, 16'hE372, 1'b1);
        drain();

        issue8(1'b1, 8'd5, 8'd6, 16'h001E, 1'b1);
        @(posedge clk);
        #1;
        issue8(1'b1, 8'd100, 8'hFA, 16'h0000, 1'b0);
        drain();
        check("ignored_hold", {16'h0, result8}, 32'h001E);

        issue8(1'b1, 8'hF1, 8'd20, 16'hFED4, 1'b1);
        for (int i = 0; i < 10 && !done8; i++) begin
            @(posedge clk);
            #1;
        end
        issue8(1'b1, 8'd64, 8'hFF, 16'hFFC0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("b2b_hold", {16'h0, result8}, 32'h0000FED4);
            @(posedge clk);
            #1;
        end
        drain();

        issue8(1'b1, 8'd3, 8'd3, 16'h0009, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'h0, busy8}, 32'h0);
        check("abort_done", {31'h0, done8}, 32'h0);
        check("abort_result", {16'h0, result8}, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_done", {16'h0, result8}, 32'h0);
        issue8(1'b1, 8'd16, 8'd8, 16'h0080, 1'b1);
        drain();

        issue16(1'b1, 16'h8000, 16'h8000, 32'h40000000);
        drain();
        issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        drain();
        issue16(1'b1, 16'd1000, 16'hFFFD, 32'hFFFFF448);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
